// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg
//   Shared constants and helpers for the binary-to-BCD converter.
//   - BIN2BCD_DEF_WIDTH  : default binary input width
//   - BIN2BCD_DEF_DIGITS : default number of BCD output digits
//   - bin2bcd_min_digits : smallest digit count that holds 2^width - 1
package bin2bcd_pkg;

    localparam int unsigned BIN2BCD_DEF_WIDTH  = 4;
    localparam int unsigned BIN2BCD_DEF_DIGITS = 2;

    // Counts decimal digits of the largest WIDTH-bit value (at least one).
    // The loop bound covers any 64-bit maximum.
    function automatic int unsigned bin2bcd_min_digits(input int unsigned width);
        longint unsigned max_val;
        longint unsigned pow10;
        int unsigned     n;
        max_val = (64'd1 << width) - 64'd1;
        pow10   = 64'd10;
        n       = 1;
        for (int unsigned k = 0; k < 20; k++) begin
            if (pow10 <= max_val) begin
                n     = n + 1;
                pow10 = pow10 * 64'd10;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// bin2bcd_if
//   Data bundle between a binary producer and the converter.
//   - bin : unsigned binary value (producer -> converter)
//   - bcd : packed BCD, ones digit in bcd[3:0] (converter -> consumer)
//   Modports: master drives bin and reads bcd; slave is the converter side.
interface bin2bcd_if
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = BIN2BCD_DEF_WIDTH,
    parameter int unsigned DIGITS = BIN2BCD_DEF_DIGITS
);

    logic [WIDTH-1:0]    bin;
    logic [4*DIGITS-1:0] bcd;

    modport master (
        output bin,
        input  bcd
    );

    modport slave (
        input  bin,
        output bcd
    );

endinterface

// File: rtl/bin2bcd_core.sv
// bin2bcd_core
//   Purely combinational double-dabble (shift-and-add-3) converter.
//   - i_bin : WIDTH-bit unsigned binary input
//   - o_bcd : DIGITS packed BCD digits, ones digit in o_bcd[3:0]
//   Scratch is {digits, binary}; each of WIDTH stages corrects every digit
//   (>= 5 gets +3) and then shifts the whole scratch left by one.
module bin2bcd_core
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = BIN2BCD_DEF_WIDTH,
    parameter int unsigned DIGITS = BIN2BCD_DEF_DIGITS
) (
    input  logic [WIDTH-1:0]    i_bin,
    output logic [4*DIGITS-1:0] o_bcd
);

    localparam int unsigned SW = WIDTH + 4*DIGITS;
    localparam int unsigned BW = 4*DIGITS;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic [SW-1:0] w_in;
        logic [SW-1:0] w_adj;

        // Stage input is the previous stage's corrected scratch shifted once.
        if (i == 0) begin : g_first
            assign w_in = SW'(i_bin);
        end else begin : g_next
            assign w_in = g_stage[i-1].w_adj << 1;
        end

        assign w_adj[WIDTH-1:0] = w_in[WIDTH-1:0];

        for (genvar j = 0; j < DIGITS; j++) begin : g_digit
            assign w_adj[WIDTH+4*j +: 4] =
                (w_in[WIDTH+4*j +: 4] >= 4'd5) ? (w_in[WIDTH+4*j +: 4] + 4'd3)
                                               :  w_in[WIDTH+4*j +: 4];
        end
    end

    // The final shift lands the binary field fully in the digit field.
    assign o_bcd = BW'((g_stage[WIDTH-1].w_adj << 1) >> WIDTH);

endmodule

// File: rtl/bin2bcd.sv
// bin2bcd
//   Registered binary-to-BCD converter, one conversion per clock, one cycle
//   latency, no handshake.
//   - clk : rising-edge clock
//   - rst : asynchronous active-low reset, clears bcd to zero
//   - bus : bin2bcd_if slave (bin in, bcd out)
module bin2bcd
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = BIN2BCD_DEF_WIDTH,
    parameter int unsigned DIGITS = BIN2BCD_DEF_DIGITS
) (
    input  logic      clk,
    input  logic      rst,
    bin2bcd_if.slave  bus
);

    if ((WIDTH == 0) || (WIDTH > 16)) begin : g_bad_width
        $error("bin2bcd: WIDTH=%0d outside 1..16", WIDTH);
    end

    if (DIGITS < bin2bcd_min_digits(WIDTH)) begin : g_bad_digits
        $error("bin2bcd: DIGITS=%0d too small for WIDTH=%0d (need %0d)",
               DIGITS, WIDTH, bin2bcd_min_digits(WIDTH));
    end

    logic [4*DIGITS-1:0] w_bcd;
    logic [4*DIGITS-1:0] r_bcd;

    bin2bcd_core #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_core (
        .i_bin (bus.bin),
        .o_bcd (w_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcd <= '0;
        end else begin
            r_bcd <= w_bcd;
        end
    end

    assign bus.bcd = r_bcd;

endmodule

// File: tb/tb_bin2bcd.sv
// tb_bin2bcd
//   Self-checking bench: a default (4-bit, 2-digit) converter and an 8-bit,
//   3-digit converter, checked against a divide/modulo decimal model.
module tb_bin2bcd;

    logic clk;
    logic rst;

    int unsigned total;
    int unsigned bad;

    bin2bcd_if #(.WIDTH(4), .DIGITS(2)) u_if_a ();
    bin2bcd_if #(.WIDTH(8), .DIGITS(3)) u_if_b ();

    bin2bcd #(.WIDTH(4), .DIGITS(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (u_if_a)
    );

    bin2bcd #(.WIDTH(8), .DIGITS(3)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (u_if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Decimal digits by repeated divide/modulo, ones digit lowest.
    function automatic logic [11:0] ref_bcd(input int unsigned v);
        logic [11:0] r;
        r = '0;
        for (int unsigned d = 0; d < 3; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int unsigned shown;
        int unsigned v;
        int unsigned lat_seq [4];

        total = 0;
        bad   = 0;
        lat_seq = '{15, 0, 9, 10};

        // Reset asserted between edges with bin=7: clear is immediate and held.
        rst = 1'b1;
        u_if_a.bin = 4'd7;
        u_if_b.bin = 8'd0;
        #2 rst = 1'b0;
        #1;
        chk("rst_async_a", {4'h0, u_if_a.bcd}, 12'h000);
        chk("rst_async_b", u_if_b.bcd, 12'h000);
        @(negedge clk);
        chk("rst_hold1_a", {4'h0, u_if_a.bcd}, 12'h000);
        @(negedge clk);
        chk("rst_hold2_a", {4'h0, u_if_a.bcd}, 12'h000);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_release_a", {4'h0, u_if_a.bcd}, 12'h007);
        chk("rst_release_b", u_if_b.bcd, 12'h000);

        // Sweep 0..15, each value held for two cycles.
        for (int unsigned s = 0; s < 16; s++) begin
            u_if_a.bin = 4'(s);
            @(negedge clk);
            chk("sweep_a", {4'h0, u_if_a.bcd}, ref_bcd(s));
            @(negedge clk);
            chk("sweep_hold_a", {4'h0, u_if_a.bcd}, ref_bcd(s));
        end
        shown = 15;

        // Back-to-back changes: nothing moves before the edge, then one-cycle latency.
        for (int unsigned k = 0; k < 4; k++) begin
            u_if_a.bin = 4'(lat_seq[k]);
            #1;
            chk("no_early_a", {4'h0, u_if_a.bcd}, ref_bcd(shown));
            @(negedge clk);
            shown = lat_seq[k];
            chk("latency_a", {4'h0, u_if_a.bcd}, ref_bcd(shown));
        end

        // Reset mid-operation while showing 14, release with bin=3.
        u_if_a.bin = 4'd14;
        @(negedge clk);
        chk("pre_midrst_a", {4'h0, u_if_a.bcd}, 12'h014);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_async_a", {4'h0, u_if_a.bcd}, 12'h000);
        u_if_a.bin = 4'd3;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_hold_a", {4'h0, u_if_a.bcd}, 12'h000);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_release_a", {4'h0, u_if_a.bcd}, 12'h003);

        // Random back-to-back values on the default converter.
        for (int unsigned k = 0; k < 100; k++) begin
            v = $urandom_range(15, 0);
            u_if_a.bin = 4'(v);
            @(negedge clk);
            chk("random_a", {4'h0, u_if_a.bcd}, ref_bcd(v));
        end

        // Exhaustive 8-bit sweep, back-to-back, on the 3-digit converter.
        for (int unsigned k = 0; k < 256; k++) begin
            u_if_b.bin = 8'(k);
            @(negedge clk);
            chk("sweep_b", u_if_b.bcd, ref_bcd(k));
        end

        // Random 8-bit values, back-to-back.
        for (int unsigned k = 0; k < 50; k++) begin
            v = $urandom_range(255, 0);
            u_if_b.bin = 8'(v);
            @(negedge clk);
            chk("random_b", u_if_b.bcd, ref_bcd(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
